// File: rtl/fsm_init_ad.sv
// Control FSM for the initialization + associated-data phase of a
// permutation-based cipher. Drives round index, input select, write enable
// and XOR mode of the permutation datapath. Pure Moore outputs.
module fsm_init_ad (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       ad_last_i,
  output logic [3:0] round_o,
  output logic       select_o,
  output logic       enable_o,
  output logic [1:0] etat_o,
  output logic       data_ready_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] ROUND_FIRST_AD = 4'd6;
  localparam logic [3:0] ROUND_LAST     = 4'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_WAIT_AD,
    S_AD,
    S_DONE
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_last;
  logic       w_last_nxt;

  // State, round counter and captured last-block flag
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Next-state, counter and flag logic; counter only reloads on transitions
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_state_nxt = S_INIT;
          w_cnt_nxt   = '0;
        end
      end
      S_INIT: begin
        if (r_cnt == ROUND_LAST) begin
          w_state_nxt = S_WAIT_AD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_WAIT_AD: begin
        if (data_valid_i) begin
          w_state_nxt = S_AD;
          w_cnt_nxt   = ROUND_FIRST_AD;
          w_last_nxt  = ad_last_i;
        end
      end
      S_AD: begin
        if (r_cnt == ROUND_LAST) begin
          w_state_nxt = r_last ? S_DONE : S_WAIT_AD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from state and counter only
  always_comb begin
    round_o      = '0;
    select_o     = 1'b0;
    enable_o     = 1'b0;
    etat_o       = 2'd0;
    data_ready_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_o = 1'b0;
      end
      S_INIT: begin
        enable_o = 1'b1;
        round_o  = r_cnt;
        select_o = (r_cnt == 4'd0);
        if (r_cnt == ROUND_LAST) etat_o = 2'd2;
      end
      S_WAIT_AD: begin
        // all datapath controls idle while waiting for AD
      end
      S_AD: begin
        enable_o = 1'b1;
        round_o  = r_cnt;
        if (r_cnt == ROUND_FIRST_AD) begin
          etat_o       = 2'd1;
          data_ready_o = 1'b1;
        end else if (r_cnt == ROUND_LAST && r_last) begin
          etat_o = 2'd3;
        end
      end
      S_DONE: begin
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fsm_init_ad.sv
// Bench for fsm_init_ad: directed scenarios plus random traffic, checked
// against a transaction-level model that expands each accepted request
// into its list of expected per-cycle outputs.
module tb_fsm_init_ad;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       dv;
  logic       last;
  logic [3:0] round;
  logic       sel;
  logic       en;
  logic [1:0] etat;
  logic       rdy;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  fsm_init_ad dut (
    .clock_i      (clk),
    .resetb_i     (rstn),
    .start_i      (start),
    .data_valid_i (dv),
    .ad_last_i    (last),
    .round_o      (round),
    .select_o     (sel),
    .enable_o     (en),
    .etat_o       (etat),
    .data_ready_o (rdy),
    .busy_o       (busy),
    .done_o       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] round;
    logic       sel;
    logic       en;
    logic [1:0] etat;
    logic       rdy;
    logic       busy;
    logic       done;
    logic       to_wait;  // after this cycle the sequence waits for AD
    logic       ad;       // this cycle belongs to an AD burst
  } exp_t;

  exp_t q[$];
  bit   m_wait;

  function automatic exp_t mk(logic [3:0] r, logic s, logic e, logic [1:0] x,
                              logic rd, logic b, logic d, logic tw, logic a);
    exp_t t;
    t.round = r; t.sel = s; t.en = e; t.etat = x; t.rdy = rd;
    t.busy = b; t.done = d; t.to_wait = tw; t.ad = a;
    return t;
  endfunction

  function automatic exp_t cur_exp();
    if (q.size() != 0) return q[0];
    if (m_wait) return mk(4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    return mk(4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // Model reaction to one rising edge given the inputs seen at that edge
  task automatic model_edge();
    exp_t t;
    if (q.size() != 0) begin
      t = q.pop_front();
      if (t.to_wait) m_wait = 1'b1;
    end else if (m_wait) begin
      if (dv) begin
        m_wait = 1'b0;
        for (int unsigned r = 6; r <= 11; r++) begin
          q.push_back(mk(4'(r), 1'b0, 1'b1,
                         (r == 6) ? 2'd1 : ((r == 11 && last) ? 2'd3 : 2'd0),
                         (r == 6), 1'b1, 1'b0, (r == 11 && !last), 1'b1));
        end
        if (last) q.push_back(mk(4'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      end
    end else if (start) begin
      for (int unsigned r = 0; r <= 11; r++) begin
        q.push_back(mk(4'(r), (r == 0), 1'b1, (r == 11) ? 2'd2 : 2'd0,
                       1'b0, 1'b1, 1'b0, (r == 11), 1'b0));
      end
    end
  endtask

  task automatic chk(string tag, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    exp_t e;
    e = cur_exp();
    chk("round",  round,        e.round);
    chk("select", {3'b0, sel},  {3'b0, e.sel});
    chk("enable", {3'b0, en},   {3'b0, e.en});
    chk("etat",   {2'b0, etat}, {2'b0, e.etat});
    chk("ready",  {3'b0, rdy},  {3'b0, e.rdy});
    chk("busy",   {3'b0, busy}, {3'b0, e.busy});
    chk("done",   {3'b0, done}, {3'b0, e.done});
    chk("round_le_11", {3'b0, (round <= 4'd11)}, 4'd1);
  endtask

  task automatic step(logic s, logic v, logic l);
    start = s; dv = v; last = l;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges, held across one edge
  task automatic async_reset();
    #2;
    rstn = 1'b0;
    #1;
    q.delete();
    m_wait = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;
  endtask

  int n;

  initial begin
    rstn = 1'b0; start = 1'b0; dv = 1'b0; last = 1'b0;
    m_wait = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rstn = 1'b1;

    // Single-block sequence with inputs held; start-to-done latency
    step(1'b1, 1'b0, 1'b0);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      step(1'b0, 1'b1, 1'b1);
      n++;
    end
    chk("start_to_done", 4'(n - 12), 4'(20 - 12));
    step(1'b0, 1'b0, 1'b0);

    // Two blocks back-to-back, first not last
    step(1'b1, 1'b0, 1'b0);
    repeat (12) step(1'b0, 1'b1, 1'b0);
    repeat (7)  step(1'b0, 1'b1, 1'b0);
    repeat (8)  step(1'b0, 1'b1, 1'b1);
    repeat (2)  step(1'b0, 1'b0, 1'b0);

    // Long wait for AD, plus start during INIT and AD ignored
    step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    repeat (8) step(1'b1, 1'b0, 1'b0);

    // Reset mid-AD at round 8, then fresh start
    step(1'b1, 1'b0, 1'b0);
    n = 0;
    while (!(cur_exp().ad && round == 4'd8) && n < 40) begin
      step(1'b0, 1'b1, 1'b0);
      n++;
    end
    chk("reach_ad_round8", round, 4'd8);
    async_reset();
    step(1'b1, 1'b0, 1'b0);
    chk("restart_round0", round, 4'd0);
    chk("restart_select", {3'b0, sel}, 4'd1);
    repeat (20) step(1'b0, 1'b1, 1'b1);

    // Random traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) async_reset();
      else step(1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
